mem_access_seq: RTL and testbench
=================================

# mem_access_seq

Parametrised data-port access sequencer for the MEM stage of the pipelined LC-3b core. It supersedes the hard-wired LDI/STI toggle and stall logic with one FSM. That FSM supports word and byte accesses at configurable data width and up to MAX_INDIRECT pointer dereferences before the final access. It drives the data memory port and the global stall that gates every pipeline register load.

## Interface
Parameters:
- WIDTH, 16, data width in bits; multiple of 8, at least 16.
- ADDR_W, 16, address width.
- MAX_INDIRECT, 1, maximum pointer reads per request; at least 1.
- LANES, WIDTH/8, derived byte-lane count.
- LVL_W, $clog2(MAX_INDIRECT+1), derived width of the level field.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  MEM stage holds a valid instruction.
- req_read  in  1  operation loads.
- req_write  in  1  operation stores; never asserted together with req_read.
- req_byte  in  1  byte-sized final access (LDB/STB).
- req_levels  in  LVL_W  number of pointer reads before the final access; 0 = direct.
- req_addr  in  ADDR_W  effective address from EX.
- req_wdata  in  WIDTH  store data; the byte is in bits [7:0].
- advance  in  1  global pipeline load; the MEM instruction leaves this cycle.
- mem_resp  in  1  memory completion strobe.
- mem_rdata  in  WIDTH  memory read data; valid with mem_resp.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_address  out  ADDR_W  access address.
- mem_wdata  out  WIDTH  write data.
- mem_wmask  out  LANES  byte-enable mask.
- rdata  out  WIDTH  load result; byte loads zero-extended.
- final_addr  out  ADDR_W  last address accessed, for WB address mux and JMP/TRAP reuse.
- stall  out  1  MEM cannot complete this cycle.

## Operation
- States: IDLE, PTR, GAP, DATA, DONE.
- A request is live when req_valid is high and either req_read or req_write is high.
- IDLE:
  - Live request: latch req_addr into addr_q and req_levels into lvl_q.
  - Go to PTR if req_levels is nonzero, otherwise DATA.
  - No live request: stay in IDLE; stall is low.
- PTR:
  - mem_read is high with mem_address = addr_q.
  - On mem_resp: addr_q <= mem_rdata[ADDR_W-1:0] and lvl_q decrements.
  - Then go to GAP.
- GAP:
  - One cycle with no strobes.
  - Go to PTR if lvl_q is nonzero, otherwise DATA.
- DATA:
  - mem_read or mem_write is high with mem_address = addr_q.
  - Word: mem_wmask is all ones and mem_wdata = req_wdata.
  - Byte: lane = addr_q[$clog2(LANES)-1:0]; mem_wmask is one-hot at that lane; mem_wdata = req_wdata[7:0] replicated across all lanes.
  - On mem_resp: capture the load result into rdata_q and go to DONE.
  - Byte load result: the selected lane is zero-extended.
- DONE:
  - No strobes; stall is low.
  - Hold rdata_q and final_addr until advance.
  - On advance, go to IDLE.
- A live request is also present in IDLE with advance high: accept it next cycle; DONE always passes through IDLE.
- Word accesses place addr_q on the bus unmodified; memory ignores the low bits.
- mem_resp outside PTR and DATA is ignored.
- Flush (req_valid falls in PTR, GAP or DATA):
  - The current handshake is finished; strobes stay high until mem_resp.
  - The result is then discarded and the FSM goes to IDLE, not DONE.
  - A write already issued still completes on the bus.

## Timing
- stall = live request AND state is not DONE. Combinational from state and request.
- Strobes and mem_address decode from state and registers only; no mem_resp-to-strobe combinational path.
- Direct word load, request at cycle t, zero-wait memory (resp in the first strobe cycle):
  - DATA at t+1, DONE at t+2.
  - stall is high in t and t+1.
- Each pointer level adds 2 cycles plus wait states.
- The zero-wait LDI cycle count is 5: IDLE, PTR, GAP, DATA, DONE.
- Reset values:
  - State IDLE; addr_q and lvl_q are 0.
  - mem_read, mem_write, mem_wmask, mem_address, mem_wdata, rdata, final_addr are all 0.
  - stall is 0.
- Reset mid-operation: return to IDLE immediately; the outstanding transaction is abandoned.

## Structure
- Add to lc3b_types:
  - mem_seq_state_t enum {IDLE, PTR, GAP, DATA, DONE}.
  - Parameter constants for default WIDTH and MAX_INDIRECT.
- One sub-module, mem_lane_align, combinational:
  - Inputs: lane, byte flag, req_wdata, mem_rdata.
  - Outputs: mem_wmask, replicated write data, extracted/zero-extended read data.
- Replaces the toggle, ldi_mux and mdr muxing in the datapath.
- load_register becomes mem_resp_a & ~stall.

## Test plan
- Direct LDR, addr 0x1000, mem_rdata 0xBEEF, 2 wait cycles -> one DATA read at 0x1000; rdata 0xBEEF in DONE; stall high exactly 4 cycles.
- STB, addr 0x2003, req_wdata 0x00A5, WIDTH=16 -> mem_wmask 2'b10, mem_wdata 0xA5A5; LDB from 0x2003 returning 0x7Fxx -> rdata 0x007F.
- LDI, addr 0x3000 returns pointer 0x4000, 0x4000 returns 0x1234 -> reads at 0x3000 then 0x4000; one strobe-free GAP cycle between them; rdata 0x1234; final_addr 0x4000.
- MAX_INDIRECT=3, req_levels=3 chained pointers -> exactly 4 reads and 3 GAP cycles; WIDTH=32 byte lane 2 gives mask 4'b0100.
- req_valid dropped in DATA with mem_resp 3 cycles later -> strobe held until resp; then IDLE, DONE never entered, stall low.
- rst_n pulsed low in PTR -> all outputs 0 asynchronously; next live request starts from IDLE.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: MEM-stage access sequencer state encoding and default
// sizing constants for the data port.
package lc3b_types;

    localparam int MEM_SEQ_WIDTH        = 16;
    localparam int MEM_SEQ_MAX_INDIRECT = 1;

    typedef enum logic [2:0] {
        IDLE,
        PTR,
        GAP,
        DATA,
        DONE
    } mem_seq_state_t;

endpackage

// File: rtl/mem_access_seq_lane_align.sv
// Byte-lane steering for the data port: write mask, replicated store byte and
// zero-extended load byte for the lane selected by the low address bits.
module mem_lane_align #(
    parameter int WIDTH = 16,
    localparam int LANES  = WIDTH / 8,
    localparam int LANE_W = $clog2(LANES)
) (
    input  logic [LANE_W-1:0] lane,
    input  logic              byte_acc,
    input  logic [WIDTH-1:0]  req_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [LANES-1:0]  wmask,
    output logic [WIDTH-1:0]  wdata_rep,
    output logic [WIDTH-1:0]  rdata_ext
);

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        wmask     = '1;
        wdata_rep = req_wdata;
        rdata_ext = mem_rdata;
        if (byte_acc) begin
            wmask     = '0;
            rdata_ext = '0;
            for (int i = 0; i < LANES; i++) begin
                wdata_rep[i*8 +: 8] = req_wdata[7:0];
                if (lane == LANE_W'(i)) begin
                    wmask[i]       = 1'b1;
                    rdata_ext[7:0] = mem_rdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_access_seq.sv
// MEM-stage data-port sequencer: optional pointer dereference chain, then one
// word or byte access, with the pipeline stall derived from state and request.
module mem_access_seq
    import lc3b_types::*;
#(
    parameter int WIDTH        = MEM_SEQ_WIDTH,
    parameter int ADDR_W       = 16,
    parameter int MAX_INDIRECT = MEM_SEQ_MAX_INDIRECT,
    localparam int LANES = WIDTH / 8,
    localparam int LVL_W = $clog2(MAX_INDIRECT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_read,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [LVL_W-1:0]  req_levels,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    input  logic              advance,
    input  logic              mem_resp,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic [LANES-1:0]  mem_wmask,
    output logic [WIDTH-1:0]  rdata,
    output logic [ADDR_W-1:0] final_addr,
    output logic              stall
);

    localparam int LANE_W = $clog2(LANES);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_INDIRECT);

    mem_seq_state_t    state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic              write_q, write_d;
    logic              byte_q, byte_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;

    logic              live;
    logic [LANES-1:0]  align_wmask;
    logic [WIDTH-1:0]  align_wdata;
    logic [WIDTH-1:0]  align_rdata;

    assign live  = req_valid & (req_read | req_write);
    assign stall = live & (state_q != DONE);

    mem_lane_align #(.WIDTH(WIDTH)) u_align (
        .lane      (addr_q[LANE_W-1:0]),
        .byte_acc  (byte_q),
        .req_wdata (wdata_q),
        .mem_rdata (mem_rdata),
        .wmask     (align_wmask),
        .wdata_rep (align_wdata),
        .rdata_ext (align_rdata)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lvl_d   = lvl_q;
        write_d = write_q;
        byte_d  = byte_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (live) begin
                    addr_d  = req_addr;
                    lvl_d   = (req_levels > LVL_MAX) ? LVL_MAX : req_levels;
                    write_d = req_write;
                    byte_d  = req_byte;
                    wdata_d = req_wdata;
                    state_d = (req_levels != '0) ? PTR : DATA;
                end
            end
            PTR: begin
                if (mem_resp) begin
                    addr_d  = mem_rdata[ADDR_W-1:0];
                    lvl_d   = lvl_q - LVL_W'(1);
                    state_d = req_valid ? GAP : IDLE;
                end
            end
            GAP: begin
                // A flush here has no handshake outstanding, so drop straight away.
                if (!req_valid)        state_d = IDLE;
                else if (lvl_q != '0)  state_d = PTR;
                else                   state_d = DATA;
            end
            DATA: begin
                if (mem_resp) begin
                    if (req_valid) begin
                        if (!write_q) rdata_d = align_rdata;
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                if (advance) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Port strobes depend only on registered state so mem_resp never loops back.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wmask   = '0;
        mem_wdata   = '0;
        case (state_q)
            PTR: begin
                mem_read    = 1'b1;
                mem_address = addr_q;
            end
            DATA: begin
                mem_read    = ~write_q;
                mem_write   = write_q;
                mem_address = addr_q;
                mem_wmask   = align_wmask;
                mem_wdata   = align_wdata;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments and every register,
    // data holding registers included, is cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lvl_q   <= '0;
            write_q <= 1'b0;
            byte_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lvl_q   <= lvl_d;
            write_q <= write_d;
            byte_q  <= byte_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata      = rdata_q;
    assign final_addr = addr_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: a 16-bit single-indirect instance driven
// step by step, plus a 32-bit triple-indirect instance fed by a zero-wait memory.
module tb_mem_access_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- 16-bit instance ----------------
    logic        a_req_valid, a_req_read, a_req_write, a_req_byte;
    logic [0:0]  a_req_levels;
    logic [15:0] a_req_addr, a_req_wdata;
    logic        a_advance, a_mem_resp;
    logic [15:0] a_mem_rdata;
    logic        a_mem_read, a_mem_write, a_stall;
    logic [15:0] a_mem_address, a_mem_wdata, a_rdata, a_final_addr;
    logic [1:0]  a_mem_wmask;

    mem_access_seq dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_read(a_req_read), .req_write(a_req_write),
        .req_byte(a_req_byte), .req_levels(a_req_levels), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .advance(a_advance), .mem_resp(a_mem_resp),
        .mem_rdata(a_mem_rdata), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .mem_address(a_mem_address), .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask),
        .rdata(a_rdata), .final_addr(a_final_addr), .stall(a_stall)
    );

    // ---------------- 32-bit, 3-level instance ----------------
    logic        b_req_valid, b_req_read, b_req_write, b_req_byte;
    logic [1:0]  b_req_levels;
    logic [15:0] b_req_addr;
    logic [31:0] b_req_wdata;
    logic        b_advance, b_mem_resp;
    logic [31:0] b_mem_rdata;
    logic        b_mem_read, b_mem_write, b_stall;
    logic [15:0] b_mem_address, b_final_addr;
    logic [31:0] b_mem_wdata, b_rdata;
    logic [3:0]  b_mem_wmask;

    mem_access_seq #(.WIDTH(32), .ADDR_W(16), .MAX_INDIRECT(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_read(b_req_read), .req_write(b_req_write),
        .req_byte(b_req_byte), .req_levels(b_req_levels), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .advance(b_advance), .mem_resp(b_mem_resp),
        .mem_rdata(b_mem_rdata), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_address(b_mem_address), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
        .rdata(b_rdata), .final_addr(b_final_addr), .stall(b_stall)
    );

    // Zero-wait memory for instance b: pointer chain 0x0100 -> 0x0200 -> 0x0300 -> 0x0402.
    function automatic logic [31:0] b_lookup(input logic [15:0] a);
        case (a)
            16'h0100: return 32'hFFFF_0200;
            16'h0200: return 32'h0000_0300;
            16'h0300: return 32'h1234_0402;
            16'h0402: return 32'h11C3_5577;
            default:  return 32'h0;
        endcase
    endfunction

    always_comb begin
        b_mem_resp  = b_mem_read | b_mem_write;
        b_mem_rdata = b_lookup(b_mem_address);
    end

    int a_stall_cnt = 0;
    always @(negedge clk) if (a_stall) a_stall_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_leave();
        a_advance   = 1'b1;
        a_req_valid = 1'b0;
        tick();
        a_advance   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    int stall_base;
    int reads, quiet;
    logic [3:0]  mask_seen;
    logic [31:0] wd_seen;

    initial begin
        a_req_valid = 0; a_req_read = 0; a_req_write = 0; a_req_byte = 0;
        a_req_levels = 0; a_req_addr = 0; a_req_wdata = 0; a_advance = 0;
        a_mem_resp = 0; a_mem_rdata = 0;
        b_req_valid = 0; b_req_read = 0; b_req_write = 0; b_req_byte = 0;
        b_req_levels = 0; b_req_addr = 0; b_req_wdata = 0; b_advance = 0;
        mask_seen = 0; wd_seen = 0;

        // Reset state
        #3;
        chk("rst_a_read",  a_mem_read, 0);
        chk("rst_a_write", a_mem_write, 0);
        chk("rst_a_addr",  a_mem_address, 0);
        chk("rst_a_mask",  a_mem_wmask, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_a_stall", a_stall, 0);
        chk("rst_b_final", b_final_addr, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Direct LDR at 0x1000 with two wait states
        a_req_valid = 1; a_req_read = 1; a_req_addr = 16'h1000; a_req_levels = 0;
        stall_base = a_stall_cnt;
        #1 chk("ldr_idle_stall", a_stall, 1);
        chk("ldr_idle_nostrobe", a_mem_read, 0);
        tick();
        chk("ldr_data_read", a_mem_read, 1);
        chk("ldr_data_addr", a_mem_address, 16'h1000);
        tick();
        chk("ldr_wait_read", a_mem_read, 1);
        tick();
        a_mem_resp = 1; a_mem_rdata = 16'hBEEF;
        tick();
        a_mem_resp = 0;
        chk("ldr_done_rdata", a_rdata, 16'hBEEF);
        chk("ldr_done_stall", a_stall, 0);
        chk("ldr_done_read", a_mem_read, 0);
        chk("ldr_stall_cycles", a_stall_cnt - stall_base, 4);
        a_leave();

        // STB to 0x2003: lane 1
        a_req_valid = 1; a_req_read = 0; a_req_write = 1; a_req_byte = 1;
        a_req_addr = 16'h2003; a_req_wdata = 16'h00A5;
        tick();
        chk("stb_write", a_mem_write, 1);
        chk("stb_read", a_mem_read, 0);
        chk("stb_mask", a_mem_wmask, 2'b10);
        chk("stb_wdata", a_mem_wdata, 16'hA5A5);
        a_mem_resp = 1;
        tick();
        a_mem_resp = 0;
        chk("stb_done_write", a_mem_write, 0);
        chk("stb_final", a_final_addr, 16'h2003);
        a_leave();

        // LDB from 0x2003 (high lane) and 0x2002 (low lane, bit 7 set)
        a_req_valid = 1; a_req_read = 1; a_req_write = 0; a_req_byte = 1;
        a_req_addr = 16'h2003;
        tick();
        chk("ldb_hi_mask", a_mem_wmask, 2'b10);
        a_mem_resp = 1; a_mem_rdata = 16'h7F12;
        tick();
        a_mem_resp = 0;
        chk("ldb_hi_rdata", a_rdata, 16'h007F);
        a_leave();
        a_req_valid = 1; a_req_addr = 16'h2002;
        tick();
        chk("ldb_lo_mask", a_mem_wmask, 2'b01);
        a_mem_resp = 1; a_mem_rdata = 16'h12F0;
        tick();
        a_mem_resp = 0;
        chk("ldb_lo_rdata", a_rdata, 16'h00F0);
        a_leave();

        // LDI: 0x3000 -> pointer 0x4000 -> 0x1234
        a_req_valid = 1; a_req_read = 1; a_req_byte = 0; a_req_levels = 1;
        a_req_addr = 16'h3000;
        stall_base = a_stall_cnt;
        tick();
        chk("ldi_ptr_read", a_mem_read, 1);
        chk("ldi_ptr_addr", a_mem_address, 16'h3000);
        a_mem_resp = 1; a_mem_rdata = 16'h4000;
        tick();
        a_mem_resp = 0;
        chk("ldi_gap_read", a_mem_read, 0);
        chk("ldi_gap_write", a_mem_write, 0);
        chk("ldi_gap_stall", a_stall, 1);
        tick();
        chk("ldi_data_read", a_mem_read, 1);
        chk("ldi_data_addr", a_mem_address, 16'h4000);
        a_mem_resp = 1; a_mem_rdata = 16'h1234;
        tick();
        a_mem_resp = 0;
        chk("ldi_rdata", a_rdata, 16'h1234);
        chk("ldi_final", a_final_addr, 16'h4000);
        chk("ldi_stall_cycles", a_stall_cnt - stall_base, 4);
        a_leave();

        // Flush in DATA: strobe held until resp, result discarded, back to IDLE
        a_req_valid = 1; a_req_read = 1; a_req_levels = 0; a_req_addr = 16'h5000;
        tick();
        a_req_valid = 0;
        #1 chk("flush_read_held0", a_mem_read, 1);
        chk("flush_stall_low", a_stall, 0);
        tick();
        chk("flush_read_held1", a_mem_read, 1);
        tick();
        a_mem_resp = 1; a_mem_rdata = 16'hDEAD;
        #1 chk("flush_read_held2", a_mem_read, 1);
        tick();
        a_mem_resp = 0;
        chk("flush_read_off", a_mem_read, 0);
        chk("flush_rdata_kept", a_rdata, 16'h1234);
        // A live request now stalls, which it would not in DONE.
        a_req_valid = 1; a_req_levels = 1; a_req_addr = 16'h6000;
        #1 chk("flush_idle_stall", a_stall, 1);
        tick();
        chk("rstmid_ptr_read", a_mem_read, 1);

        // Asynchronous reset while in PTR
        #1 a_req_valid = 0; rst_n = 0;
        #1;
        chk("rstmid_read", a_mem_read, 0);
        chk("rstmid_addr", a_mem_address, 0);
        chk("rstmid_wdata", a_mem_wdata, 0);
        chk("rstmid_rdata", a_rdata, 0);
        chk("rstmid_final", a_final_addr, 0);
        chk("rstmid_stall", a_stall, 0);
        @(negedge clk) rst_n = 1;
        tick();
        a_req_valid = 1; a_req_read = 1; a_req_levels = 1; a_req_addr = 16'h7000;
        #1 chk("post_rst_idle_read", a_mem_read, 0);
        tick();
        chk("post_rst_ptr_addr", a_mem_address, 16'h7000);
        a_mem_resp = 1; a_mem_rdata = 16'h7100;
        tick();
        a_mem_resp = 0;
        tick();
        chk("post_rst_data_addr", a_mem_address, 16'h7100);
        a_mem_resp = 1; a_mem_rdata = 16'hCAFE;
        tick();
        a_mem_resp = 0;
        chk("post_rst_rdata", a_rdata, 16'hCAFE);
        a_leave();

        // 32-bit, three chained pointers then a byte load from lane 2
        b_req_valid = 1; b_req_read = 1; b_req_byte = 1; b_req_levels = 3;
        b_req_addr = 16'h0100; b_req_wdata = 32'h0000_005A;
        reads = 0; quiet = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (b_mem_read) reads++;
            if (b_stall && !b_mem_read && !b_mem_write) quiet++;
            if (b_mem_read && b_mem_address == 16'h0402) begin
                mask_seen = b_mem_wmask;
                wd_seen   = b_mem_wdata;
            end
            if (!b_stall) break;
            tick();
        end
        chk("b_done_stall", b_stall, 0);
        chk("b_reads", reads, 4);
        chk("b_idle_plus_gaps", quiet, 4);
        chk("b_mask_lane2", mask_seen, 4'b0100);
        chk("b_wdata_rep", wd_seen, 32'h5A5A_5A5A);
        chk("b_rdata", b_rdata, 32'h0000_00C3);
        chk("b_final", b_final_addr, 16'h0402);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
